// File: rtl/frame_config_mem.sv
// frame_config_mem
//   Double-banked configuration frame store. Frames are written into a
//   shadow bank (parity and range checked), then a Commit copies the whole
//   shadow bank into the active bank one frame per cycle. The active bank
//   drives ConfigBits / ConfigBits_N and is visible through a one-cycle
//   readback port.
//
// Ports
//   CLK, resetn        clock, asynchronous active-low reset
//   FrameData/Parity   write data and even-parity bit
//   FrameAddr          write frame index
//   FrameValid/Ready   write handshake (Ready low while copying)
//   Commit/CommitDone  start shadow->active copy / one-cycle completion pulse
//   RbAddr/RbReq       readback request
//   RbData/RbValid     readback response, one cycle after the request
//   ConfigBits(_N)     active configuration and its complement
//   ErrFlags/ErrClr    sticky {range, parity} error flags and their clear
module frame_config_mem #(
    parameter int FRAME_BITS = 32,
    parameter int NUM_FRAMES = 20,
    parameter int AW         = 5
) (
    input  logic                             CLK,
    input  logic                             resetn,
    input  logic [FRAME_BITS-1:0]            FrameData,
    input  logic                             FrameParity,
    input  logic [AW-1:0]                    FrameAddr,
    input  logic                             FrameValid,
    output logic                             FrameReady,
    input  logic                             Commit,
    output logic                             CommitDone,
    input  logic [AW-1:0]                    RbAddr,
    input  logic                             RbReq,
    output logic [FRAME_BITS-1:0]            RbData,
    output logic                             RbValid,
    output logic [NUM_FRAMES*FRAME_BITS-1:0] ConfigBits,
    output logic [NUM_FRAMES*FRAME_BITS-1:0] ConfigBits_N,
    output logic [1:0]                       ErrFlags,
    input  logic                             ErrClr
);

    typedef enum logic {IDLE, COPY} state_e;

    state_e                                 state_q, state_d;
    logic [AW-1:0]                          idx_q, idx_d;
    logic [NUM_FRAMES-1:0][FRAME_BITS-1:0]  shadow_q, shadow_d;
    logic [NUM_FRAMES-1:0][FRAME_BITS-1:0]  active_q, active_d;
    logic [1:0]                             err_q, err_d;
    logic [FRAME_BITS-1:0]                  rb_data_q, rb_data_d;
    logic                                   rb_valid_q, rb_valid_d;
    logic                                   done_q, done_d;
    logic                                   wr_acc, addr_ok, par_ok, copy_last;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        err_d      = err_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = RbReq;
        done_d     = 1'b0;
        addr_ok    = 1'b0;
        wr_acc     = FrameValid && (state_q == IDLE);
        par_ok     = ~^{FrameData, FrameParity};
        copy_last  = (idx_q == AW'(NUM_FRAMES - 1));

        // Address decode doubles as the range check: an index that matches
        // no frame is out of range.
        for (int f = 0; f < NUM_FRAMES; f++) begin
            if (FrameAddr == AW'(f)) begin
                addr_ok = 1'b1;
                if (wr_acc && par_ok) shadow_d[f] = FrameData;
            end
        end

        // Clear first so a same-cycle error event keeps its flag set.
        if (ErrClr)             err_d    = 2'b00;
        if (wr_acc && !par_ok)  err_d[0] = 1'b1;
        if (wr_acc && !addr_ok) err_d[1] = 1'b1;

        // Out-of-range readback matches no frame and returns zero.
        if (RbReq) begin
            rb_data_d = '0;
            for (int f = 0; f < NUM_FRAMES; f++) begin
                if (RbAddr == AW'(f)) rb_data_d = active_q[f];
            end
        end

        case (state_q)
            IDLE: begin
                // A write on this edge has already been folded into
                // shadow_d, so the copy starting next cycle sees it.
                if (Commit) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                // Commit is deliberately not looked at here.
                for (int f = 0; f < NUM_FRAMES; f++) begin
                    if (idx_q == AW'(f)) active_d[f] = shadow_q[f];
                end
                idx_d = idx_q + AW'(1);
                if (copy_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            err_q      <= 2'b00;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            err_q      <= err_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            done_q     <= done_d;
        end
    end

    assign FrameReady   = (state_q == IDLE);
    assign CommitDone   = done_q;
    assign RbData       = rb_data_q;
    assign RbValid      = rb_valid_q;
    assign ErrFlags     = err_q;
    // Packed bank flattens with frame 0 in the least significant bits.
    assign ConfigBits   = active_q;
    assign ConfigBits_N = ~active_q;

endmodule

// File: tb/tb_frame_config_mem.sv
// Self-checking bench for frame_config_mem. A small bank model tracks the
// expected shadow/active contents; readback expectations are queued when a
// request is driven and compared when RbValid returns.
module tb_frame_config_mem;
    localparam int FB = 32;
    localparam int NF = 20;
    localparam int AW = 5;
    localparam int CW = NF * FB;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [FB-1:0] FrameData;
    logic          FrameParity;
    logic [AW-1:0] FrameAddr;
    logic          FrameValid;
    logic          FrameReady;
    logic          Commit;
    logic          CommitDone;
    logic [AW-1:0] RbAddr;
    logic          RbReq;
    logic [FB-1:0] RbData;
    logic          RbValid;
    logic [CW-1:0] ConfigBits;
    logic [CW-1:0] ConfigBits_N;
    logic [1:0]    ErrFlags;
    logic          ErrClr;

    int checks = 0;
    int failures = 0;

    logic [FB-1:0] shadow_m [NF];
    logic [FB-1:0] active_m [NF];
    logic [FB-1:0] sb_q [$];

    frame_config_mem #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .AW(AW)) dut (
        .CLK(CLK), .resetn(resetn),
        .FrameData(FrameData), .FrameParity(FrameParity), .FrameAddr(FrameAddr),
        .FrameValid(FrameValid), .FrameReady(FrameReady),
        .Commit(Commit), .CommitDone(CommitDone),
        .RbAddr(RbAddr), .RbReq(RbReq), .RbData(RbData), .RbValid(RbValid),
        .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N),
        .ErrFlags(ErrFlags), .ErrClr(ErrClr)
    );

    always #5 CLK = ~CLK;

    // Expected ConfigBits with the first ncopied frames taken from shadow.
    function automatic logic [CW-1:0] cfg_of(input int ncopied);
        logic [CW-1:0] v;
        for (int f = 0; f < NF; f++) v[f*FB +: FB] = (f < ncopied) ? shadow_m[f] : active_m[f];
        return v;
    endfunction

    task automatic commit_model();
        for (int f = 0; f < NF; f++) active_m[f] = shadow_m[f];
    endtask

    task automatic clear_model();
        for (int f = 0; f < NF; f++) begin
            shadow_m[f] = '0;
            active_m[f] = '0;
        end
    endtask

    // One-cycle write while idle; returns at the negedge after the capture edge.
    task automatic write_frame(input int a, input logic [FB-1:0] d, input logic bad_par);
        @(negedge CLK);
        FrameValid  = 1'b1;
        FrameAddr   = AW'(a);
        FrameData   = d;
        FrameParity = (^d) ^ bad_par;
        if (a < NF && !bad_par) shadow_m[a] = d;
        @(negedge CLK);
        FrameValid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (ConfigBits !== '0) begin failures++; $display("FAIL rst_cfg got=%h exp=0", ConfigBits); end
        checks++; if (ConfigBits_N !== '1) begin failures++; $display("FAIL rst_cfg_n got=%h exp=all ones", ConfigBits_N); end
        checks++; if (ErrFlags !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", ErrFlags); end
        checks++; if (RbValid !== 1'b0) begin failures++; $display("FAIL rst_rbvalid got=%b exp=0", RbValid); end
        checks++; if (RbData !== '0) begin failures++; $display("FAIL rst_rbdata got=%h exp=0", RbData); end
        checks++; if (CommitDone !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", CommitDone); end
        resetn = 1'b1;
        @(negedge CLK);
        checks++; if (FrameReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", FrameReady); end
    endtask

    task automatic test_write_commit();
        int done = 0;
        write_frame(3, 32'h0000_0001, 1'b0);
        write_frame(0, 32'hA5A5_0F0F, 1'b0);
        write_frame(19, 32'hDEAD_BEEF, 1'b0);
        checks++; if (ConfigBits !== cfg_of(0)) begin failures++; $display("FAIL wr_no_cfg got=%h exp=%h", ConfigBits, cfg_of(0)); end
        @(negedge CLK); Commit = 1'b1;
        @(negedge CLK); Commit = 1'b0;
        // Here we sit at the negedge right after the Commit sampling edge.
        for (int k = 0; k <= NF + 2; k++) begin
            checks++; if (ConfigBits !== cfg_of(k < NF ? k : NF)) begin
                failures++; $display("FAIL copy_cfg k=%0d got=%h exp=%h", k, ConfigBits, cfg_of(k < NF ? k : NF));
            end
            checks++; if (FrameReady !== (k >= NF)) begin failures++; $display("FAIL copy_ready k=%0d got=%b exp=%b", k, FrameReady, k >= NF); end
            checks++; if (CommitDone !== (k == NF)) begin failures++; $display("FAIL copy_done k=%0d got=%b exp=%b", k, CommitDone, k == NF); end
            if (CommitDone === 1'b1) done++;
            @(negedge CLK);
        end
        commit_model();
        checks++; if (done != 1) begin failures++; $display("FAIL done_count got=%0d exp=1", done); end
        checks++; if (ConfigBits[127:96] !== 32'h0000_0001) begin failures++; $display("FAIL frame3 got=%h exp=00000001", ConfigBits[127:96]); end
        checks++; if (ConfigBits_N[127:96] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL frame3_n got=%h exp=fffffffe", ConfigBits_N[127:96]); end
        checks++; if (ConfigBits_N !== ~cfg_of(0)) begin failures++; $display("FAIL cfg_n got=%h exp=%h", ConfigBits_N, ~cfg_of(0)); end
    endtask

    task automatic test_parity_err();
        write_frame(5, 32'h0000_0003, 1'b1);
        checks++; if (ErrFlags !== 2'b01) begin failures++; $display("FAIL par_err got=%b exp=01", ErrFlags); end
        // Clear collides with a new parity error: the error must win.
        @(negedge CLK);
        ErrClr = 1'b1; FrameValid = 1'b1; FrameAddr = AW'(6); FrameData = 32'h7; FrameParity = 1'b0;
        @(negedge CLK);
        ErrClr = 1'b0; FrameValid = 1'b0;
        checks++; if (ErrFlags !== 2'b01) begin failures++; $display("FAIL par_clr_race got=%b exp=01", ErrFlags); end
        @(negedge CLK); ErrClr = 1'b1;
        @(negedge CLK); ErrClr = 1'b0;
        checks++; if (ErrFlags !== 2'b00) begin failures++; $display("FAIL par_clr got=%b exp=00", ErrFlags); end
    endtask

    task automatic test_addr_err();
        write_frame(25, 32'h1234_5678, 1'b0);
        checks++; if (ErrFlags !== 2'b10) begin failures++; $display("FAIL addr_err got=%b exp=10", ErrFlags); end
        @(negedge CLK); ErrClr = 1'b1;
        @(negedge CLK); ErrClr = 1'b0;
        write_frame(26, 32'h0000_0001, 1'b1);
        checks++; if (ErrFlags !== 2'b11) begin failures++; $display("FAIL both_err got=%b exp=11", ErrFlags); end
        @(negedge CLK); ErrClr = 1'b1;
        @(negedge CLK); ErrClr = 1'b0;
        checks++; if (ErrFlags !== 2'b00) begin failures++; $display("FAIL addr_clr got=%b exp=00", ErrFlags); end
    endtask

    task automatic test_readback();
        int addrs [7] = '{3, 5, 25, 0, 19, 31, 3};
        logic [FB-1:0] exp;
        for (int i = 0; i <= 7; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                checks++; if (RbValid !== 1'b1) begin failures++; $display("FAIL rb_valid i=%0d got=%b exp=1", i - 1, RbValid); end
                exp = sb_q.pop_front();
                checks++; if (RbData !== exp) begin failures++; $display("FAIL rb_data addr=%0d got=%h exp=%h", addrs[i-1], RbData, exp); end
            end
            if (i < 7) begin
                RbReq  = 1'b1;
                RbAddr = AW'(addrs[i]);
                sb_q.push_back(addrs[i] < NF ? active_m[addrs[i]] : '0);
            end else begin
                RbReq = 1'b0;
            end
        end
        @(negedge CLK);
        checks++; if (RbValid !== 1'b0) begin failures++; $display("FAIL rb_idle got=%b exp=0", RbValid); end
        checks++; if (ErrFlags !== 2'b00) begin failures++; $display("FAIL rb_no_err got=%b exp=00", ErrFlags); end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL rb_sb_left got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_busy_commit();
        int rdy_low = 0;
        int done = 0;
        int done_k = -1;
        write_frame(7, 32'h0F0F_1234, 1'b0);
        @(negedge CLK); Commit = 1'b1;
        @(negedge CLK); Commit = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (FrameReady === 1'b0) rdy_low++;
            if (CommitDone === 1'b1) begin done++; done_k = k; end
            // Writes offered during the copy must be refused.
            FrameValid  = (k < 15);
            FrameAddr   = AW'(8);
            FrameData   = 32'hBAD0_0008;
            FrameParity = ^FrameData;
            Commit      = (k == 10);
            @(negedge CLK);
        end
        FrameValid = 1'b0; Commit = 1'b0;
        commit_model();
        checks++; if (rdy_low != NF) begin failures++; $display("FAIL busy_ready_low got=%0d exp=%0d", rdy_low, NF); end
        checks++; if (done != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done); end
        checks++; if (done_k != NF) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=%0d", done_k, NF); end
        checks++; if (ConfigBits !== cfg_of(0)) begin failures++; $display("FAIL busy_cfg got=%h exp=%h", ConfigBits, cfg_of(0)); end
    endtask

    task automatic test_commit_write_same_edge();
        logic got = 1'b0;
        @(negedge CLK);
        FrameValid = 1'b1; FrameAddr = AW'(0); FrameData = 32'h5555_AAAA; FrameParity = ^FrameData;
        Commit = 1'b1;
        shadow_m[0] = 32'h5555_AAAA;
        @(negedge CLK);
        FrameValid = 1'b0; Commit = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (CommitDone === 1'b1) got = 1'b1;
            else @(negedge CLK);
        end
        commit_model();
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL same_edge_done got=%b exp=1 (timeout)", got); end
        checks++; if (ConfigBits[31:0] !== 32'h5555_AAAA) begin failures++; $display("FAIL same_edge_f0 got=%h exp=5555aaaa", ConfigBits[31:0]); end
        checks++; if (ConfigBits !== cfg_of(0)) begin failures++; $display("FAIL same_edge_cfg got=%h exp=%h", ConfigBits, cfg_of(0)); end
    endtask

    task automatic test_reset_mid_copy();
        int done = 0;
        logic got = 1'b0;
        write_frame(1, 32'hCAFE_0001, 1'b0);
        @(negedge CLK); Commit = 1'b1;
        @(negedge CLK); Commit = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (ConfigBits !== cfg_of(10)) begin failures++; $display("FAIL mid_partial got=%h exp=%h", ConfigBits, cfg_of(10)); end
        resetn = 1'b0;
        #1;
        clear_model();
        checks++; if (ConfigBits !== '0) begin failures++; $display("FAIL mid_rst_cfg got=%h exp=0", ConfigBits); end
        checks++; if (ConfigBits_N !== '1) begin failures++; $display("FAIL mid_rst_cfg_n got=%h exp=all ones", ConfigBits_N); end
        checks++; if (FrameReady !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", FrameReady); end
        @(posedge CLK); #2 resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (CommitDone === 1'b1) done++;
        end
        checks++; if (done != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done); end
        checks++; if (FrameReady !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", FrameReady); end
        // Shadow must have been wiped too: a fresh commit yields all zeros.
        @(negedge CLK); Commit = 1'b1;
        @(negedge CLK); Commit = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (CommitDone === 1'b1) got = 1'b1;
            else @(negedge CLK);
        end
        commit_model();
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL post_rst_done got=%b exp=1 (timeout)", got); end
        checks++; if (ConfigBits !== cfg_of(0)) begin failures++; $display("FAIL post_rst_cfg got=%h exp=%h", ConfigBits, cfg_of(0)); end
    endtask

    initial begin
        FrameData = '0; FrameParity = 1'b0; FrameAddr = '0; FrameValid = 1'b0;
        Commit = 1'b0; RbAddr = '0; RbReq = 1'b0; ErrClr = 1'b0;
        clear_model();
        test_reset();
        test_write_commit();
        test_parity_err();
        test_addr_err();
        test_readback();
        test_busy_commit();
        test_commit_write_same_edge();
        test_reset_mid_copy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
